// File: rtl/dac_pkg.sv
// Shared definitions for the DAC playback controller.
//   play_state_e : playback FSM state encoding (IDLE / FETCH / READY)
//   MIN_DIV      : smallest divider reload value. It guarantees a one-cycle-latency
//                  memory read can complete before the first sample tick.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } play_state_e;

  localparam int MIN_DIV = 3;

endpackage

// File: rtl/dac_playback_ctrl_if.sv
// Sample-memory read bus between the playback controller (master) and the
// sample memory (slave).
//   Mem_Rd_Req  : read request, held until Mem_Rd_Ack
//   Mem_Rd_Addr : word address, stable while Mem_Rd_Req is high
//   Mem_Rd_Ack  : read data valid this cycle
//   Mem_Rd_Data : {I sample (upper half), Q sample (lower half)}
interface dac_playback_ctrl_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 20
);

  logic                  Mem_Rd_Req;
  logic [ADDR_WIDTH-1:0] Mem_Rd_Addr;
  logic                  Mem_Rd_Ack;
  logic [DATA_WIDTH-1:0] Mem_Rd_Data;

  modport master (
    output Mem_Rd_Req,
    output Mem_Rd_Addr,
    input  Mem_Rd_Ack,
    input  Mem_Rd_Data
  );

  modport slave (
    input  Mem_Rd_Req,
    input  Mem_Rd_Addr,
    output Mem_Rd_Ack,
    output Mem_Rd_Data
  );

endinterface

// File: rtl/dac_rate_div.sv
// Loadable sample-rate down-counter.
//   clk, rst_n : clock and synchronous active-low reset
//   load       : load load_val into the counter and keep it as the reload value
//   load_val   : period minus one, in clocks
//   en         : count enable; the tick is suppressed while disabled
//   tick       : one-cycle pulse whenever the enabled count reaches zero
// The counter reloads on the cycle after it reaches zero, so the tick
// period is load_val + 1 clocks.
module dac_rate_div #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  input  logic                 en,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] reload;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples its pre-edge inputs, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      reload <= '0;
    end else if (load) begin
      cnt    <= load_val;
      reload <= load_val;
    end else if (en) begin
      cnt <= (cnt == '0) ? reload : cnt - DIV_WIDTH'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/dac_playback_ctrl.sv
// DAC playback controller: fetches {I,Q} sample words from memory ahead of
// time, then presents them to the DAC at a programmable sample rate.
//   SPLB_Clk, SPLB_Rst_n      : clock and synchronous active-low reset
//   Cfg_Start / Cfg_Stop      : one-cycle start / abort pulses (Stop wins)
//   Cfg_Loop, Cfg_Last        : wrap enable and last word address
//   Cfg_Div                   : sample period minus one (at least MIN_DIV is used)
//   mem                       : sample-memory read bus (master side)
//   DAC_I, DAC_Q, DAC_Valid   : registered samples plus update strobe
//   DAC_PWRDN                 : power-down request while idle
//   Sts_Busy, Sts_Underrun    : activity and sticky underrun status
// Optional build macro DAC_PLAYBACK_UNDERRUN_CNT_EN adds Sts_Underrun_Cnt,
// an 8-bit saturating count of missed sample ticks.
module dac_playback_ctrl
  import dac_pkg::*;
#(
  parameter int DAC_WIDTH  = 10,
  parameter int ADDR_WIDTH = 14,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  SPLB_Clk,
  input  logic                  SPLB_Rst_n,
  input  logic                  Cfg_Start,
  input  logic                  Cfg_Stop,
  input  logic                  Cfg_Loop,
  input  logic [ADDR_WIDTH-1:0] Cfg_Last,
  input  logic [DIV_WIDTH-1:0]  Cfg_Div,
  dac_playback_ctrl_if.master   mem,
  output logic [DAC_WIDTH-1:0]  DAC_I,
  output logic [DAC_WIDTH-1:0]  DAC_Q,
  output logic                  DAC_Valid,
  output logic                  DAC_PWRDN,
  output logic                  Sts_Busy,
  output logic                  Sts_Underrun
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
  ,
  output logic [7:0]            Sts_Underrun_Cnt
`endif
);

  play_state_e                state;
  play_state_e                state_next;
  logic [ADDR_WIDTH-1:0]      addr;
  logic [ADDR_WIDTH-1:0]      last_q;
  logic                       loop_q;
  logic                       last_staged;  // staged word is the final one of a one-shot run
  logic [2*DAC_WIDTH-1:0]     stage;
  logic                       start;
  logic                       tick;
  logic                       capture;
  logic                       play;
  logic                       underrun_evt;
  logic [DIV_WIDTH-1:0]       div_load;

  assign start    = Cfg_Start && !Cfg_Stop;
  assign div_load = (Cfg_Div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : Cfg_Div;

  dac_rate_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_div (
    .clk      (SPLB_Clk),
    .rst_n    (SPLB_Rst_n),
    .load     (start),
    .load_val (div_load),
    .en       (state != IDLE),
    .tick     (tick)
  );

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    play         = 1'b0;
    underrun_evt = 1'b0;
    if (Cfg_Stop) begin
      state_next = IDLE;
    end else if (Cfg_Start) begin
      state_next = FETCH;
    end else begin
      unique case (state)
        IDLE: ;
        FETCH: begin
          // A tick while still fetching means the stage register is empty.
          underrun_evt = tick;
          if (mem.Mem_Rd_Ack) begin
            capture    = 1'b1;
            state_next = READY;
          end
        end
        READY: begin
          if (tick) begin
            play       = 1'b1;
            state_next = last_staged ? IDLE : FETCH;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge SPLB_Clk) begin
    if (!SPLB_Rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      last_q       <= '0;
      loop_q       <= 1'b0;
      last_staged  <= 1'b0;
      stage        <= '0;
      DAC_I        <= '0;
      DAC_Q        <= '0;
      DAC_Valid    <= 1'b0;
      Sts_Underrun <= 1'b0;
    end else begin
      state     <= state_next;
      DAC_Valid <= play;
      if (play) begin
        {DAC_I, DAC_Q} <= stage;
      end
      if (Cfg_Stop) begin
        last_staged <= 1'b0;
      end else if (start) begin
        addr         <= '0;
        stage        <= '0;
        last_staged  <= 1'b0;
        Sts_Underrun <= 1'b0;
        last_q       <= Cfg_Last;
        loop_q       <= Cfg_Loop;
      end else begin
        if (capture) begin
          stage <= mem.Mem_Rd_Data;
          if (addr == last_q) begin
            if (loop_q) addr <= '0;
            else        last_staged <= 1'b1;
          end else begin
            addr <= addr + ADDR_WIDTH'(1);
          end
        end
        if (underrun_evt) begin
          Sts_Underrun <= 1'b1;
        end
      end
    end
  end

`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
  always_ff @(posedge SPLB_Clk) begin
    if (!SPLB_Rst_n || start) begin
      Sts_Underrun_Cnt <= '0;
    end else if (underrun_evt && (Sts_Underrun_Cnt != 8'hFF)) begin
      Sts_Underrun_Cnt <= Sts_Underrun_Cnt + 8'd1;
    end
  end
`else
  // Counter build option disabled: only the sticky flag reports underruns.
`endif

  assign mem.Mem_Rd_Req  = (state == FETCH);
  assign mem.Mem_Rd_Addr = addr;
  assign Sts_Busy        = (state != IDLE);
  assign DAC_PWRDN       = !Sts_Busy;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed testbench for dac_playback_ctrl: a behavioural sample memory with
// programmable acknowledge latency, a strobe monitor, and hand-derived
// expected strobe times and sample words.
module tb_dac_playback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [13:0] last = '0;
  logic [15:0] div = '0;
  logic [9:0]  dac_i;
  logic [9:0]  dac_q;
  logic        dac_valid;
  logic        dac_pwrdn;
  logic        busy;
  logic        underrun;
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;

  int          ack_dly = 1;
  int          rd_cnt = 0;
  logic        auto_ack = 1'b0;
  logic [19:0] rd_data = '0;
  logic        force_ack = 1'b0;
  logic [19:0] force_data = '0;

  int          st_cyc[$];
  logic [19:0] st_dat[$];
  int          ack_addr[$];

  dac_playback_ctrl_if #(.ADDR_WIDTH(14), .DATA_WIDTH(20)) mem_bus ();

  dac_playback_ctrl dut (
    .SPLB_Clk     (clk),
    .SPLB_Rst_n   (rst_n),
    .Cfg_Start    (start),
    .Cfg_Stop     (stop),
    .Cfg_Loop     (loop_en),
    .Cfg_Last     (last),
    .Cfg_Div      (div),
    .mem          (mem_bus.master),
    .DAC_I        (dac_i),
    .DAC_Q        (dac_q),
    .DAC_Valid    (dac_valid),
    .DAC_PWRDN    (dac_pwrdn),
    .Sts_Busy     (busy),
    .Sts_Underrun (underrun)
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    ,
    .Sts_Underrun_Cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] mem_word(input int a);
    return {10'(a + 16), 10'(700 - a)};
  endfunction

  // Sample memory: acknowledges ack_dly negedges after the request is first seen.
  assign mem_bus.Mem_Rd_Ack  = auto_ack | force_ack;
  assign mem_bus.Mem_Rd_Data = force_ack ? force_data : rd_data;

  always @(negedge clk) begin
    if (auto_ack) begin
      auto_ack = 1'b0;
      rd_cnt   = 0;
    end else if (mem_bus.Mem_Rd_Req) begin
      if (rd_cnt >= ack_dly) begin
        auto_ack = 1'b1;
        rd_data  = mem_word(int'(mem_bus.Mem_Rd_Addr));
        ack_addr.push_back(int'(mem_bus.Mem_Rd_Addr));
      end else begin
        rd_cnt++;
      end
    end else begin
      rd_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (dac_valid) begin
      st_cyc.push_back(cyc);
      st_dat.push_back({dac_i, dac_q});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses Cfg_Start with the given configuration; returns the cycle stamp of
  // the start edge (strobe stamps are taken relative to it).
  task automatic run_start(input logic [13:0] l, input logic [15:0] d, input logic lp,
                           output int c_start);
    st_cyc.delete();
    st_dat.delete();
    ack_addr.delete();
    last    = l;
    div     = d;
    loop_en = lp;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    c_start = cyc;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pwrdn"}, dac_pwrdn, 1'b1);
    check({tag, "_req"}, mem_bus.Mem_Rd_Req, 1'b0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_dac", {dac_i, dac_q}, 20'h0);
    check("rst_valid", dac_valid, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // One-shot, 4 words, period 10, one-cycle ack latency.
    run_start(14'd3, 16'd9, 1'b0, c0);
    repeat (45) @(negedge clk);
    check("r34_count", st_cyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("r34_cyc%0d", k), st_cyc[k] - c0, 10 * (k + 1));
      check($sformatf("r34_dat%0d", k), st_dat[k], mem_word(k));
    end
    check_idle("r34_end");
    check("r34_underrun", underrun, 1'b0);

    // Cfg_Div=0 is raised to the minimum: strobes every 4 clocks.
    run_start(14'd2, 16'd0, 1'b0, c0);
    repeat (17) @(negedge clk);
    check("r36_count", st_cyc.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("r36_cyc%0d", k), st_cyc[k] - c0, 4 * (k + 1));
      check($sformatf("r36_dat%0d", k), st_dat[k], mem_word(k));
    end
    check_idle("r36_end");

    // Slow memory: underruns at ticks 4 and 8 while outputs hold word 2.
    ack_dly = 8;
    run_start(14'd1, 16'd3, 1'b0, c0);
    repeat (9) @(negedge clk);
    check("r37_underrun", underrun, 1'b1);
    check("r37_hold", {dac_i, dac_q}, mem_word(2));
    check("r37_nostrobe", st_cyc.size(), 0);
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    check("r37_cnt_mid", underrun_cnt, 8'd2);
`endif
    repeat (17) @(negedge clk);
    check("r37_count", st_cyc.size(), 2);
    check("r37_cyc0", st_cyc[0] - c0, 12);
    check("r37_cyc1", st_cyc[1] - c0, 24);
    check("r37_dat0", st_dat[0], mem_word(0));
    check("r37_dat1", st_dat[1], mem_word(1));
    check("r37_sticky", underrun, 1'b1);
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    check("r37_cnt_end", underrun_cnt, 8'd4);
`endif
    check_idle("r37_end");
    ack_dly = 1;

    // Looping over two words until stopped; start clears the underrun flag.
    run_start(14'd1, 16'd5, 1'b1, c0);
    check("r35_underrun_clr", underrun, 1'b0);
    repeat (31) @(negedge clk);
    check("r35_count", st_cyc.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("r35_cyc%0d", k), st_cyc[k] - c0, 6 * (k + 1));
      check($sformatf("r35_dat%0d", k), st_dat[k], mem_word(k % 2));
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("r35_addr%0d", k), ack_addr[k], k % 2);
    end
    check("r35_busy", busy, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("r35_stop");

    // Restart while busy fetches address 0 again; Start+Stop together stops.
    run_start(14'd3, 16'd9, 1'b0, c0);
    repeat (14) @(negedge clk);
    run_start(14'd3, 16'd9, 1'b0, c0);
    check("rs_req", mem_bus.Mem_Rd_Req, 1'b1);
    check("rs_addr", mem_bus.Mem_Rd_Addr, 14'd0);
    repeat (11) @(negedge clk);
    check("rs_count", st_cyc.size(), 1);
    check("rs_cyc0", st_cyc[0] - c0, 10);
    check("rs_dat0", st_dat[0], mem_word(0));
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check_idle("rs_startstop");

    // Stop with a request pending, then a late ack that must be ignored.
    ack_dly = 100;
    run_start(14'd3, 16'd9, 1'b0, c0);
    repeat (2) @(negedge clk);
    check("r38_req_pending", mem_bus.Mem_Rd_Req, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("r38_stop");
    force_data = 20'h5A5A5;
    force_ack  = 1'b1;
    @(negedge clk);
    force_ack  = 1'b0;
    repeat (20) @(negedge clk);
    check("r38_nostrobe", st_cyc.size(), 0);
    check_idle("r38_late_ack");
    check("r38_hold", {dac_i, dac_q}, mem_word(0));

    // Reset in the middle of an underrunning loop.
    ack_dly = 8;
    run_start(14'd1, 16'd3, 1'b1, c0);
    repeat (14) @(negedge clk);
    check("rm_pre_underrun", underrun, 1'b1);
    check("rm_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("rm");
    check("rm_dac", {dac_i, dac_q}, 20'h0);
    check("rm_valid", dac_valid, 1'b0);
    check("rm_underrun", underrun, 1'b0);
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    check("rm_cnt", underrun_cnt, 8'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_playback_ctrl.md
DAC_PLAYBACK_CTRL -- requirements
Module: dac_playback_ctrl

Interface
REQ-001 SHALL have parameter DAC_WIDTH, default 10, bits per DAC channel sample.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, sample-memory word address width.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, sample-rate divider width.
REQ-004 SplB_Clk is not used; the ports SHALL be: SPLB_Clk  in  1  sole clock, all logic on rising edge.
REQ-005 SPLB_Rst_n  in  1  reset, synchronous, active-low.
REQ-006 Cfg_Start  in  1  one-cycle pulse, begin playback from address 0.
REQ-007 Cfg_Stop  in  1  one-cycle pulse, abort playback.
REQ-008 Cfg_Loop  in  1  1 = wrap to address 0 after last word.
REQ-009 Cfg_Last  in  ADDR_WIDTH  address of last sample word.
REQ-010 Cfg_Div  in  DIV_WIDTH  sample period minus one, in clocks.
REQ-011 Mem_Rd_Req  out  1  read request, held until Mem_Rd_Ack.
REQ-012 Mem_Rd_Addr  out  ADDR_WIDTH  read address, stable while Mem_Rd_Req=1.
REQ-013 Mem_Rd_Ack  in  1  read data valid this cycle.
REQ-014 Mem_Rd_Data  in  2*DAC_WIDTH  {I sample upper half, Q sample lower half}.
REQ-015 DAC_I / DAC_Q  out  DAC_WIDTH each  registered channel samples to the DAC datapath.
REQ-016 DAC_Valid  out  1  one-cycle strobe when DAC_I/DAC_Q update.
REQ-017 DAC_PWRDN  out  1  DAC power-down request, 1 when idle.
REQ-018 Sts_Busy  out  1  playback active; Sts_Underrun  out  1  sticky underrun flag.

Function
REQ-019 States SHALL be IDLE, FETCH, READY; IDLE->FETCH on Cfg_Start.
REQ-020 FETCH SHALL assert Mem_Rd_Req; on Mem_Rd_Ack capture data into the stage register, advance the address, go to READY.
REQ-021 Effective period SHALL be max(Cfg_Div,3)+1 clocks; divider reloads on Cfg_Start and raises one-cycle tick at count zero.
REQ-022 On tick in READY, the stage register SHALL be copied to DAC_I/DAC_Q with DAC_Valid=1 in the following cycle; state returns to FETCH.
REQ-023 On tick in FETCH (stage empty), DAC_I/DAC_Q SHALL hold, DAC_Valid SHALL stay 0, Sts_Underrun SHALL set.
REQ-024 Address wrap: after fetching Cfg_Last, next address SHALL be 0 if Cfg_Loop=1; otherwise no further fetch, the staged word plays at its tick, then IDLE.
REQ-025 Cfg_Stop SHALL force IDLE next cycle; an outstanding Mem_Rd_Req SHALL drop and a late Mem_Rd_Ack SHALL be ignored.
REQ-026 Cfg_Start while busy SHALL restart from address 0 and clear the stage register; Cfg_Start and Cfg_Stop together: Stop wins.
REQ-027 Sts_Underrun SHALL clear only on Cfg_Start or reset; Sts_Busy=1 in FETCH/READY; DAC_PWRDN=~Sts_Busy.
REQ-028 Cfg_* SHALL be sampled at Cfg_Start; later changes take effect at next start.

Reset
REQ-029 SPLB_Rst_n=0 at a clock edge SHALL give IDLE, address 0, divider 0, DAC_I/DAC_Q=0, DAC_Valid=0, Mem_Rd_Req=0, Sts_Busy=0, Sts_Underrun=0, DAC_PWRDN=1, regardless of state.

Configuration
REQ-030 With DAC_PLAYBACK_UNDERRUN_CNT_EN defined, SHALL add output Sts_Underrun_Cnt (8 bits), saturating at 255, incremented per REQ-023 event, cleared on start/reset.
REQ-031 Without it, the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package dac_pkg SHALL hold the state enum type and constant MIN_DIV=3.
REQ-033 Sub-module dac_rate_div (loadable down-counter emitting tick) SHALL implement REQ-021.

Verification
REQ-034 Cfg_Last=3, Cfg_Div=9, Loop=0, Ack one cycle after Req -> exactly 4 DAC_Valid strobes 10 clocks apart, data words 0..3, then IDLE, DAC_PWRDN=1.
REQ-035 Cfg_Last=1, Loop=1 -> addresses 0,1,0,1... and DAC outputs alternate indefinitely until Cfg_Stop; IDLE next cycle.
REQ-036 Cfg_Div=0 -> strobes every 4 clocks.
REQ-037 Cfg_Div=3, Ack delayed 8 clocks -> Sts_Underrun=1, outputs hold; with macro, Sts_Underrun_Cnt counts missed ticks.
REQ-038 Cfg_Stop during pending Req, Ack next cycle -> ack ignored, no strobe; SPLB_Rst_n=0 mid-playback -> all outputs at REQ-029 values next cycle.
